exception_seq: RTL
==================

EXCEPTION_SEQ -- requirements
Module: exception_seq

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 1, meaning memory read wait cycles between address issue and data capture (legal range 1..3).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port exc_opcode  input  1  invalid-opcode event, level-sampled.
REQ-005 SHALL have port exc_ovf  input  1  ALU overflow event, level-sampled.
REQ-006 SHALL have port exc_div0  input  1  divide-by-zero event, level-sampled.
REQ-007 SHALL have port pc_in  input  32  current PC value.
REQ-008 SHALL have port mem_data  input  32  memory read data.
REQ-009 SHALL have port iord_sel  output  3  memory-address mux selector.
REQ-010 SHALL have port mem_rd  output  1  memory read strobe.
REQ-011 SHALL have port epc_wr, epc_val  output  1, 32  EPC write strobe and value.
REQ-012 SHALL have port pc_wr, pc_val  output  1, 32  PC write strobe and handler address.
REQ-013 SHALL have port stall  output  1  holds main control FSM while sequence runs.
REQ-014 SHALL have port exc_done  output  1  one-cycle pulse on sequence completion.
REQ-015 SHALL have port cause  output  2  latched cause code (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE, SAVE, ADDR, WAIT, LOAD.
REQ-017 IDLE: any event high at clock edge -> SAVE next cycle; otherwise stay IDLE.
REQ-018 Priority on simultaneous events: exc_opcode > exc_ovf > exc_div0; winner latched at IDLE->SAVE transition, losers discarded.
REQ-019 Vector selector: opcode -> 3'b010 (addr 253), ovf -> 3'b011 (254), div0 -> 3'b100 (255).
REQ-020 SAVE (1 cycle): epc_wr=1, epc_val = pc_in - 4 mod 2^32 (pc_in=0 -> 0xFFFFFFFC); iord_sel=3'b000.
REQ-021 ADDR (1 cycle): iord_sel=latched vector, mem_rd=1.
REQ-022 WAIT (exactly MEM_WAIT cycles, down-counter): iord_sel held at vector, mem_rd=1.
REQ-023 LOAD (1 cycle): pc_val = {24'b0, mem_data[7:0]}, pc_wr=1, exc_done=1; iord_sel held; next state IDLE.
REQ-024 Total occupancy SHALL be 3+MEM_WAIT cycles; stall=1 in every non-IDLE state, 0 in IDLE.
REQ-025 Events arriving while not IDLE SHALL be ignored, not queued.
REQ-026 Event still high on return to IDLE SHALL start a new sequence (re-trigger), with no idle gap required.
REQ-027 In IDLE: iord_sel=3'b000, all strobes 0; epc_val/pc_val SHALL hold last registered values.
REQ-028 All outputs SHALL be registered or decoded solely from state registers; no input-to-output combinational path.

Reset
REQ-029 reset high at a clock edge SHALL force IDLE regardless of state, including mid-WAIT.
REQ-030 Reset values: iord_sel=3'b000, mem_rd=0, epc_wr=0, pc_wr=0, stall=0, exc_done=0, epc_val=0, pc_val=0, cause=2'b00, wait counter=0.
REQ-031 Events sampled in the same cycle as reset SHALL be ignored.

Configuration
REQ-032 Macro EXC_CAUSE_REG_EN defined: cause SHALL be loaded in SAVE (opcode=2'b01, ovf=2'b10, div0=2'b11) and hold until the next SAVE or reset.
REQ-033 Macro EXC_CAUSE_REG_EN undefined: cause SHALL be constant 2'b00, no cause register synthesised; all other behaviour identical.

Verification
REQ-034 exc_ovf pulsed 1 cycle, pc_in=0x00000040, mem_data=0x000000A7, MEM_WAIT=1 -> epc_wr with epc_val=0x3C, iord_sel=3'b011 for 3 cycles, pc_wr with pc_val=0xA7, exc_done 4 cycles after trigger.
REQ-035 exc_opcode, exc_ovf and exc_div0 high together -> iord_sel=3'b010; with EXC_CAUSE_REG_EN cause=2'b01.
REQ-036 pc_in=0x00000000, exc_div0 -> epc_val=0xFFFFFFFC, iord_sel=3'b100, mem_data=0xFFFFFF12 -> pc_val=0x00000012.
REQ-037 reset asserted during WAIT with MEM_WAIT=3 -> next cycle IDLE, stall=0, no pc_wr, all reset values present.
REQ-038 exc_div0 pulsed during ADDR of an ovf sequence -> ignored; exc_ovf held high continuously -> back-to-back sequences, stall low for at most the one IDLE cycle.

Source files
------------

// File: rtl/exception_seq.sv
// Exception entry sequencer: saves EPC, fetches the handler byte from the vector table, loads PC.
// Optional feature: define EXC_CAUSE_REG_EN to keep a latched cause code; otherwise cause is tied to 2'b00.
module exception_seq #(
  parameter int MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_div0,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data,
  output logic [2:0]  iord_sel,
  output logic        mem_rd,
  output logic        epc_wr,
  output logic [31:0] epc_val,
  output logic        pc_wr,
  output logic [31:0] pc_val,
  output logic        stall,
  output logic        exc_done,
  output logic [1:0]  cause
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SAVE = 3'd1;
  localparam logic [2:0] ADDR = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] LOAD = 3'd4;

  localparam logic [1:0] WAIT_INIT = 2'(MEM_WAIT - 1);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [2:0]  vec;
  logic [2:0]  vec_sel;
  logic [1:0]  wait_cnt;
  logic [31:0] epc_q;
  logic [31:0] pc_q;
  logic        any_exc;
  logic        unused_mem_bits;

  assign any_exc         = exc_opcode | exc_ovf | exc_div0;
  assign unused_mem_bits = ^mem_data[31:8];

  // Fixed priority: opcode beats overflow beats divide-by-zero.
  always_comb begin
    vec_sel = 3'b000;
    if (exc_opcode)    vec_sel = 3'b010;
    else if (exc_ovf)  vec_sel = 3'b011;
    else if (exc_div0) vec_sel = 3'b100;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_exc) state_nxt = SAVE;
      SAVE:    state_nxt = ADDR;
      ADDR:    state_nxt = WAIT;
      WAIT:    if (wait_cnt == 2'd0) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The wait counter is armed in ADDR so WAIT lasts exactly MEM_WAIT cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      vec      <= 3'b000;
      wait_cnt <= 2'd0;
      epc_q    <= 32'd0;
      pc_q     <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_exc) begin
        vec   <= vec_sel;
        epc_q <= pc_in - 32'd4;
      end
      if (state == ADDR) begin
        wait_cnt <= WAIT_INIT;
      end else if (state == WAIT && wait_cnt != 2'd0) begin
        wait_cnt <= wait_cnt - 2'd1;
      end
      if (state == WAIT && wait_cnt == 2'd0) begin
        pc_q <= {24'd0, mem_data[7:0]};
      end
    end
  end

  assign iord_sel = (state == ADDR || state == WAIT || state == LOAD) ? vec : 3'b000;
  assign mem_rd   = (state == ADDR) || (state == WAIT);
  assign epc_wr   = (state == SAVE);
  assign pc_wr    = (state == LOAD);
  assign exc_done = (state == LOAD);
  assign stall    = (state != IDLE);
  assign epc_val  = epc_q;
  assign pc_val   = pc_q;

`ifdef EXC_CAUSE_REG_EN
  logic [1:0] cause_q;
  logic [1:0] cause_sel;

  always_comb begin
    cause_sel = 2'b00;
    if (exc_opcode)    cause_sel = 2'b01;
    else if (exc_ovf)  cause_sel = 2'b10;
    else if (exc_div0) cause_sel = 2'b11;
  end

  // Loaded together with the vector so the code is visible from SAVE onward.
  always_ff @(posedge clk) begin
    if (reset) begin
      cause_q <= 2'b00;
    end else if (state == IDLE && any_exc) begin
      cause_q <= cause_sel;
    end
  end

  assign cause = cause_q;
`else
  assign cause = 2'b00;
`endif

endmodule
